wide_alu_seq: RTL
=================

Name: wide_alu_seq

Overview:
Multi-cycle controller that runs a WIDTH*LIMBS-bit operation on one WIDTH-bit alu instance. It processes one limb per clock, least significant limb first, and chains the carry or borrow between limbs. It sits between an operand/opcode producer and a result consumer, with a valid/ready handshake on each side. The alu opcode map is unchanged: 000 NOP(pass B), 001 LD(pass B), 010 ADD, 011 SUB, 100 NOT A, 101 AND, 110 OR, 111 XOR.

Parameters:
WIDTH, 8, bit width of the shared alu, one limb; must be >= 2
LIMBS, 4, number of limbs per operation; must be >= 1; full operand width W = WIDTH*LIMBS

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_op  in  3  alu opcode
req_a  in  W  operand A
req_b  in  W  operand B
req_ci  in  1  carry/borrow into limb 0
rsp_valid  out  1  result present
rsp_ready  in  1  consumer accepts result
rsp_result  out  W  full-width result
rsp_co  out  1  carry/borrow out of top limb (ADD/SUB only, else 0)
rsp_ov  out  1  signed overflow of full-width op (ADD/SUB only, else 0)
rsp_zero  out  1  rsp_result == 0

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While rst_n=0: state=IDLE; idx, carry, op/operand registers, rsp_result, rsp_co, rsp_ov all 0; rsp_valid=0; req_ready forced 0.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready: latch op, a, b; carry<=req_ci; idx<=0; go to RUN.
  - RUN: req_ready=0. alu in_a = a[idx*WIDTH +: WIDTH], in_b = b[idx limb], ci = carry.
    - At each edge: result[idx limb] <= alu result; carry <= alu co; idx <= idx+1.
    - When idx==LIMBS-1: rsp_co <= alu co, rsp_ov <= alu ov, go to DONE. Co/ov from lower limbs are discarded.
  - DONE: rsp_valid=1; rsp_* held stable. On rsp_ready go to IDLE. rsp_zero is combinational from the result register.
- Latency:
  - rsp_valid rises exactly LIMBS cycles after the accepting edge.
  - Minimum request-to-request spacing is LIMBS+2 cycles: one bubble in IDLE after the response handshake.
  - LIMBS=1 gives a single RUN cycle.
- Arithmetic:
  - SUB chains borrow: limb i computes a_i - b_i - borrow_{i-1}, with borrow_{-1} = req_ci. rsp_co=1 means an unsigned borrow occurred.
  - ADD/SUB results wrap modulo 2^W.
  - Overflow is taken from the top limb only, which gives correct signed overflow for the full W bits.
  - Logic ops, NOT, NOP and LD ignore ci and carry. Their rsp_co and rsp_ov are 0 because the alu reports 0.
- Boundaries:
  - req_valid outside IDLE is ignored; the requester must hold its request.
  - rsp_ready outside DONE is ignored.
  - rsp_valid held with rsp_ready=0 stays in DONE indefinitely with outputs unchanged.
  - Reset mid-RUN or in DONE drops the operation; no response is produced.
  - idx never exceeds LIMBS-1.

Test Plan:
All cases use WIDTH=8, LIMBS=4.
1. ADD a=0x000000FF, b=0x00000001, ci=0 -> result 0x00000100, co=0, ov=0, zero=0; rsp_valid exactly 4 cycles after accept.
2. ADD a=0xFFFFFFFF, b=0x00000001, ci=0 -> result 0x00000000, co=1, ov=0, zero=1. ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, ov=1, co=0.
3. SUB a=0x00000000, b=0x00000001, ci=0 -> result 0xFFFFFFFF, co=1, ov=0. SUB a=0x80000000, b=1 -> result 0x7FFFFFFF, ov=1, co=0. SUB a=5, b=2, ci=1 -> result 0x00000002, co=0.
4. NOT a=0x0F0F0F0F -> 0xF0F0F0F0, co=0, ov=0. LD b=0x12345678, ci=1 -> 0x12345678, co=0. AND 0xFF00FF00 & 0x0FF00FF0 -> 0x0F000F00.
5. Back-pressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_* stable and req_ready=0 throughout. Offer a second request concurrently -> it is not accepted until the cycle after the response handshake.
6. Assert rst_n=0 in the 2nd RUN cycle -> rsp_valid=0 and outputs 0 immediately. After release, req_ready=1 and no stale response appears. A fresh ADD 1+1 returns 0x00000002.

Source files
------------

// File: rtl/wide_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : wide_alu_seq (+ wide_alu_seq_alu limb alu)
// Brief    : Multi-cycle WIDTH*LIMBS-bit ALU built on one WIDTH-bit alu,
//            one limb per clock, LSB limb first, carry/borrow chained.
// Revision : 1.0 - initial release
// ============================================================================

module wide_alu_seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             ci,
    output logic [WIDTH-1:0] result,
    output logic             co,
    output logic             ov
);
    localparam logic [2:0] C_OP_NOP = 3'b000;
    localparam logic [2:0] C_OP_LD  = 3'b001;
    localparam logic [2:0] C_OP_ADD = 3'b010;
    localparam logic [2:0] C_OP_SUB = 3'b011;
    localparam logic [2:0] C_OP_NOT = 3'b100;
    localparam logic [2:0] C_OP_AND = 3'b101;
    localparam logic [2:0] C_OP_OR  = 3'b110;
    localparam logic [2:0] C_OP_XOR = 3'b111;

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    assign w_sum  = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, ci};
    // Bit WIDTH of the difference is the unsigned borrow out.
    assign w_diff = {1'b0, in_a} - {1'b0, in_b} - {{WIDTH{1'b0}}, ci};

    always_comb begin
        result = '0;
        co     = 1'b0;
        ov     = 1'b0;
        case (op)
            C_OP_NOP, C_OP_LD: result = in_b;
            C_OP_ADD: begin
                result = w_sum[WIDTH-1:0];
                co     = w_sum[WIDTH];
                ov     = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            C_OP_SUB: begin
                result = w_diff[WIDTH-1:0];
                co     = w_diff[WIDTH];
                ov     = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                         (w_diff[WIDTH-1] != in_a[WIDTH-1]);
            end
            C_OP_NOT: result = ~in_a;
            C_OP_AND: result = in_a & in_b;
            C_OP_OR:  result = in_a | in_b;
            C_OP_XOR: result = in_a ^ in_b;
            default:  result = '0;
        endcase
    end
endmodule

module wide_alu_seq #(
    parameter int WIDTH = 8,
    parameter int LIMBS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_op,
    input  logic [WIDTH*LIMBS-1:0] req_a,
    input  logic [WIDTH*LIMBS-1:0] req_b,
    input  logic                   req_ci,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH*LIMBS-1:0] rsp_result,
    output logic                   rsp_co,
    output logic                   rsp_ov,
    output logic                   rsp_zero
);
    localparam int IDXW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [IDXW-1:0] C_LAST = IDXW'(LIMBS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                        r_state;
    logic [IDXW-1:0]               r_idx;
    logic                          r_carry;
    logic [2:0]                    r_op;
    logic [LIMBS-1:0][WIDTH-1:0]   r_a;
    logic [LIMBS-1:0][WIDTH-1:0]   r_b;
    logic [LIMBS-1:0][WIDTH-1:0]   r_result;
    logic                          r_co;
    logic                          r_ov;

    logic [WIDTH-1:0]              w_alu_result;
    logic                          w_alu_co;
    logic                          w_alu_ov;

    wide_alu_seq_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op     (r_op),
        .in_a   (r_a[r_idx]),
        .in_b   (r_b[r_idx]),
        .ci     (r_carry),
        .result (w_alu_result),
        .co     (w_alu_co),
        .ov     (w_alu_ov)
    );

    // req_ready must read 0 while reset is held, even though the state is IDLE.
    assign req_ready  = rst_n && (r_state == ST_IDLE);
    assign rsp_valid  = (r_state == ST_DONE);
    assign rsp_result = r_result;
    assign rsp_co     = r_co;
    assign rsp_ov     = r_ov;
    assign rsp_zero   = (r_result == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_co     <= 1'b0;
            r_ov     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op    <= req_op;
                        r_a     <= req_a;
                        r_b     <= req_b;
                        r_carry <= req_ci;
                        r_idx   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_result[r_idx] <= w_alu_result;
                    r_carry         <= w_alu_co;
                    // Only the top limb's flags describe the full-width op.
                    if (r_idx == C_LAST) begin
                        r_co    <= w_alu_co;
                        r_ov    <= w_alu_ov;
                        r_idx   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
